// File: rtl/gcm_stream_sequencer.sv
// gcm_stream_sequencer: feeds one AES-GCM job from a typed AAD/payload block stream to the GCM core
module gcm_stream_sequencer #(
  parameter int LEN_W = 32
) (
  input  logic         iClk,
  input  logic         iRst,
  input  logic         iStart,
  input  logic [0:127] iData,
  input  logic         iData_valid,
  input  logic         iData_type,
  input  logic [4:0]   iData_bytes,
  input  logic         iData_last,
  output logic         oData_ready,
  output logic         oCoreInit,
  output logic [0:127] oCoreAad,
  output logic         oCoreAad_valid,
  output logic         oCoreAad_last,
  output logic [0:127] oCoreBlock,
  output logic         oCoreBlock_valid,
  output logic         oCoreBlock_last,
  input  logic         iCoreReady,
  input  logic         iCoreResult_valid,
  input  logic         iCoreTag_valid,
  output logic [0:15]  oMask,
  output logic         oBusy,
  output logic         oDone,
  output logic         oErr
);
  typedef enum logic [2:0] {IDLE, START, AAD, DATA, WAIT_RES, LEN, TAG_WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic hk_q, hk_d, hold_q, hold_d, last_q, last_d;
  logic [LEN_W-1:0] aad_cnt_q, aad_cnt_d, pay_cnt_q, pay_cnt_d, aad_sat, pay_sat;
  logic [LEN_W:0] aad_sum, pay_sum;
  logic [0:127] aad_q, aad_d, blk_q, blk_d, pad;
  logic [0:15] mask_q, mask_d, bmask;
  logic aad_v_q, aad_v_d, aad_l_q, aad_l_d, blk_v_q, blk_v_d, blk_l_q, blk_l_d;
  logic init_q, init_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [4:0] nb;
  logic acc, drop, pay_take;
  assign oData_ready = (state_q == AAD & iCoreReady & !aad_v_q) | state_q == DATA;
  assign acc = iData_valid & oData_ready;
  assign drop = iData_bytes == 5'd0 & !iData_last;
  assign pay_take = acc & !drop & iData_type & nb != 5'd0;
  assign aad_sum = {1'b0, aad_cnt_q} + {{(LEN_W - 4){1'b0}}, nb};
  assign pay_sum = {1'b0, pay_cnt_q} + {{(LEN_W - 4){1'b0}}, nb};
  assign aad_sat = aad_sum[LEN_W] ? '1 : aad_sum[LEN_W-1:0];
  assign pay_sat = pay_sum[LEN_W] ? '1 : pay_sum[LEN_W-1:0];
  assign {oCoreInit, oCoreAad, oCoreAad_valid, oCoreAad_last} = {init_q, aad_q, aad_v_q, aad_l_q};
  assign {oCoreBlock, oCoreBlock_valid, oCoreBlock_last, oMask} = {blk_q, blk_v_q, blk_l_q, mask_q};
  assign {oBusy, oDone, oErr} = {busy_q, done_q, err_q};
  // Clamp the byte count to a full block and zero every byte past it
  always_comb begin
    nb = iData_bytes > 5'd16 ? 5'd16 : iData_bytes;
    for (int i = 0; i < 16; i++) begin
      bmask[i] = 5'(i) < nb;
      pad[8*i +: 8] = bmask[i] ? iData[8*i +: 8] : 8'h00;
    end
  end
  // Job sequencing: strobes fire the cycle after the beat is taken; a payload beat
  // taken in AAD waits one extra cycle so the AAD-last strobe precedes it
  always_comb begin
    state_d = state_q;
    hk_d = hk_q;
    hold_d = 1'b0;
    last_d = last_q;
    aad_cnt_d = aad_cnt_q;
    pay_cnt_d = pay_cnt_q;
    aad_d = aad_q;
    blk_d = blk_q;
    mask_d = mask_q;
    aad_v_d = 1'b0;
    aad_l_d = 1'b0;
    blk_v_d = hold_q;
    blk_l_d = hold_q & last_q;
    err_d = err_q | (acc & (drop | iData_bytes > 5'd16));
    case (state_q)
      IDLE: if (iStart) begin
        state_d = START;
        hk_d = 1'b0;
        aad_cnt_d = '0;
        pay_cnt_d = '0;
        aad_d = '0;
        err_d = 1'b0;
      end
      START: begin
        hk_d = hk_q | iCoreResult_valid;
        if (iCoreReady & hk_d) state_d = AAD;
      end
      AAD: if (acc & !drop) begin
        aad_l_d = iData_type | iData_last;
        if (!iData_type) begin
          aad_v_d = nb != 5'd0;
          if (nb != 5'd0) aad_d = pad;
          aad_cnt_d = aad_sat;
          err_d = err_d | aad_sum[LEN_W];
          if (iData_last) state_d = LEN;
        end else if (nb == 5'd0) begin
          blk_l_d = 1'b1;
          state_d = LEN;
        end else begin
          hold_d = 1'b1;
          state_d = WAIT_RES;
        end
      end
      DATA: if (acc & !drop) begin
        if (!iData_type) begin
          err_d = 1'b1;
          if (iData_last) state_d = LEN;
        end else if (nb == 5'd0) begin
          blk_l_d = 1'b1;
          state_d = LEN;
        end else begin
          blk_v_d = 1'b1;
          blk_l_d = iData_last;
          state_d = WAIT_RES;
        end
      end
      WAIT_RES: if (iCoreResult_valid & !hold_q) state_d = last_q ? LEN : DATA;
      LEN: begin
        aad_d = {64'(aad_cnt_q) << 3, 64'(pay_cnt_q) << 3};
        if (iCoreReady & !aad_v_q) begin
          aad_v_d = 1'b1;
          state_d = TAG_WAIT;
        end
      end
      TAG_WAIT: if (iCoreTag_valid) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (pay_take) begin
      blk_d = pad;
      mask_d = bmask;
      last_d = iData_last;
      pay_cnt_d = pay_sat;
      err_d = err_d | pay_sum[LEN_W];
    end
    init_d = state_d != IDLE & state_d != DONE;
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
  end
  // State and registered outputs; reset abandons any job in flight
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= IDLE;
      {hk_q, hold_q, last_q, aad_v_q, aad_l_q, blk_v_q, blk_l_q} <= '0;
      {init_q, busy_q, done_q, err_q} <= '0;
      aad_cnt_q <= '0;
      pay_cnt_q <= '0;
      aad_q <= '0;
      blk_q <= '0;
      mask_q <= '1;
    end else begin
      state_q <= state_d;
      {hk_q, hold_q, last_q, aad_v_q, aad_l_q, blk_v_q, blk_l_q} <= {hk_d, hold_d, last_d, aad_v_d, aad_l_d, blk_v_d, blk_l_d};
      {init_q, busy_q, done_q, err_q} <= {init_d, busy_d, done_d, err_d};
      aad_cnt_q <= aad_cnt_d;
      pay_cnt_q <= pay_cnt_d;
      aad_q <= aad_d;
      blk_q <= blk_d;
      mask_q <= mask_d;
    end
  end
endmodule

// File: tb/tb_gcm_stream_sequencer.sv
// tb_gcm_stream_sequencer: scoreboard bench with a small GCM core model driving the handshakes
module tb_gcm_stream_sequencer;
  logic iClk, iRst, iStart;
  logic [0:127] iData;
  logic iData_valid, iData_type, iData_last;
  logic [4:0] iData_bytes;
  logic iCoreReady, iCoreResult_valid, iCoreTag_valid;
  logic oData_ready, oCoreInit, oCoreAad_valid, oCoreAad_last, oCoreBlock_valid, oCoreBlock_last;
  logic [0:127] oCoreAad, oCoreBlock;
  logic [0:15] oMask;
  logic oBusy, oDone, oErr;
  logic r8, i8, av8, al8, bv8, bl8, by8, dn8, e8;
  logic [0:127] a8, b8;
  logic [0:15] m8;

  typedef struct { logic [0:127] d; logic l; logic len; } aad_e;
  typedef struct { logic [0:127] d; logic l; logic [0:15] m; } blk_e;
  aad_e exp_aad[$];
  blk_e exp_blk[$];
  int n_cmp = 0, n_fail = 0;
  int hk_cnt = 0, res_cnt = 0, tag_cnt = 0;
  int aad_last_cnt = 0, done_cnt = 0, blk_cnt = 0;
  logic outstanding = 0, tag_seen = 0, init_prev = 0;

  gcm_stream_sequencer #(.LEN_W(32)) u_dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iData(iData), .iData_valid(iData_valid),
    .iData_type(iData_type), .iData_bytes(iData_bytes), .iData_last(iData_last),
    .oData_ready(oData_ready), .oCoreInit(oCoreInit), .oCoreAad(oCoreAad),
    .oCoreAad_valid(oCoreAad_valid), .oCoreAad_last(oCoreAad_last), .oCoreBlock(oCoreBlock),
    .oCoreBlock_valid(oCoreBlock_valid), .oCoreBlock_last(oCoreBlock_last),
    .iCoreReady(iCoreReady), .iCoreResult_valid(iCoreResult_valid), .iCoreTag_valid(iCoreTag_valid),
    .oMask(oMask), .oBusy(oBusy), .oDone(oDone), .oErr(oErr));

  gcm_stream_sequencer #(.LEN_W(8)) u_dut8 (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iData(iData), .iData_valid(iData_valid),
    .iData_type(iData_type), .iData_bytes(iData_bytes), .iData_last(iData_last),
    .oData_ready(r8), .oCoreInit(i8), .oCoreAad(a8),
    .oCoreAad_valid(av8), .oCoreAad_last(al8), .oCoreBlock(b8),
    .oCoreBlock_valid(bv8), .oCoreBlock_last(bl8),
    .iCoreReady(iCoreReady), .iCoreResult_valid(iCoreResult_valid), .iCoreTag_valid(iCoreTag_valid),
    .oMask(m8), .oBusy(by8), .oDone(dn8), .oErr(e8));

  initial begin
    iClk = 0;
    forever #5 iClk = ~iClk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  function automatic logic [0:127] pad_of(input logic [0:127] d, input int n);
    logic [0:127] p = '0;
    for (int i = 0; i < n && i < 16; i++) p[8*i +: 8] = d[8*i +: 8];
    return p;
  endfunction

  function automatic logic [0:15] mask_of(input int n);
    logic [0:15] m = '0;
    for (int i = 0; i < n && i < 16; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Core model and scoreboard monitor, sampled on the falling edge
  initial begin
    aad_e ea;
    blk_e eb;
    iCoreReady = 1; iCoreResult_valid = 0; iCoreTag_valid = 0;
    forever begin
      @(negedge iClk);
      iCoreResult_valid = 0;
      iCoreTag_valid = 0;
      if (iRst) begin
        hk_cnt = 0; res_cnt = 0; tag_cnt = 0; outstanding = 0; init_prev = 0;
      end else begin
        if (hk_cnt > 0) begin hk_cnt--; if (hk_cnt == 0) iCoreResult_valid = 1; end
        if (res_cnt > 0) begin res_cnt--; if (res_cnt == 0) begin iCoreResult_valid = 1; outstanding = 0; end end
        if (tag_cnt > 0) begin tag_cnt--; if (tag_cnt == 0) begin iCoreTag_valid = 1; tag_seen = 1; end end
        if (oCoreInit && !init_prev) hk_cnt = 2;
        init_prev = oCoreInit;
        if (oCoreAad_last) aad_last_cnt++;
        if (oCoreAad_valid) begin
          n_cmp++;
          if (exp_aad.size() == 0) begin
            n_fail++; $display("FAIL aad_unexpected: got %h, required no strobe", oCoreAad);
          end else begin
            ea = exp_aad.pop_front();
            if (oCoreAad !== ea.d || oCoreAad_last !== ea.l) begin
              n_fail++; $display("FAIL aad_block: got %h last=%b, required %h last=%b", oCoreAad, oCoreAad_last, ea.d, ea.l);
            end
            if (ea.len) tag_cnt = 3;
          end
        end
        if (oCoreBlock_valid) begin
          blk_cnt++;
          n_cmp++;
          if (outstanding) begin n_fail++; $display("FAIL blk_overlap: got strobe before result, required one outstanding"); end
          n_cmp++;
          if (aad_last_cnt !== 1) begin n_fail++; $display("FAIL aad_last_before_blk: got %0d pulses, required 1", aad_last_cnt); end
          n_cmp++;
          if (exp_blk.size() == 0) begin
            n_fail++; $display("FAIL blk_unexpected: got %h, required no strobe", oCoreBlock);
          end else begin
            eb = exp_blk.pop_front();
            if (oCoreBlock !== eb.d || oCoreBlock_last !== eb.l || oMask !== eb.m) begin
              n_fail++;
              $display("FAIL blk: got %h last=%b mask=%h, required %h last=%b mask=%h", oCoreBlock, oCoreBlock_last, oMask, eb.d, eb.l, eb.m);
            end
          end
          outstanding = 1;
          res_cnt = 3;
        end
        if (oDone) begin
          done_cnt++;
          n_cmp++;
          if (!tag_seen) begin n_fail++; $display("FAIL done_before_tag: got oDone, required iCoreTag_valid first"); end
        end
      end
    end
  end

  task automatic send_beat(input logic typ, input int nb, input logic last, input logic push);
    logic [0:127] d;
    int k = 0;
    d = {$urandom, $urandom, $urandom, $urandom};
    if (push && typ) exp_blk.push_back('{pad_of(d, nb), last, mask_of(nb)});
    if (push && !typ) exp_aad.push_back('{pad_of(d, nb), last, 1'b0});
    iData = d; iData_type = typ; iData_bytes = 5'(nb); iData_last = last; iData_valid = 1;
    while (!oData_ready && k < 200) begin @(negedge iClk); k++; end
    if (k >= 200) begin
      n_cmp++; n_fail++; $display("FAIL beat_timeout: got ready=0 for 200 cycles, required ready");
    end else @(posedge iClk);
    @(negedge iClk);
    iData_valid = 0;
  endtask

  task automatic push_len(input longint a, input longint p);
    exp_aad.push_back('{{64'(a * 8), 64'(p * 8)}, 1'b0, 1'b1});
  endtask

  task automatic start_job();
    aad_last_cnt = 0; done_cnt = 0; tag_seen = 0; blk_cnt = 0;
    iStart = 1;
    @(negedge iClk);
    iStart = 0;
    n_cmp++;
    if (oErr !== 0) begin n_fail++; $display("FAIL start_err: got %b, required 0", oErr); end
    n_cmp++;
    if (oBusy !== 1 || oCoreInit !== 1) begin n_fail++; $display("FAIL start_busy: got busy=%b init=%b, required 1 1", oBusy, oCoreInit); end
  endtask

  task automatic wait_done();
    int k = 0;
    while (done_cnt == 0 && k < 300) begin @(negedge iClk); k++; end
    n_cmp++;
    if (done_cnt == 0) begin n_fail++; $display("FAIL done_timeout: got no oDone, required one"); end
    repeat (3) @(negedge iClk);
    n_cmp++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL done_count: got %0d, required 1", done_cnt); end
    n_cmp++;
    if (oBusy !== 0 || oCoreInit !== 0) begin n_fail++; $display("FAIL idle_after_done: got busy=%b init=%b, required 0 0", oBusy, oCoreInit); end
    n_cmp++;
    if (exp_aad.size() != 0 || exp_blk.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_left: got %0d aad %0d blk pending, required 0 0", exp_aad.size(), exp_blk.size());
    end
  endtask

  task automatic test_reset();
    iRst = 1; iStart = 0; iData = '0; iData_valid = 0; iData_type = 0; iData_bytes = 0; iData_last = 0;
    repeat (2) @(negedge iClk);
    n_cmp++;
    if ({oData_ready, oBusy, oCoreInit, oDone, oErr, oCoreAad_valid, oCoreBlock_valid} !== 7'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b, required 0000000", {oData_ready, oBusy, oCoreInit, oDone, oErr, oCoreAad_valid, oCoreBlock_valid});
    end
    n_cmp++;
    if (oMask !== 16'hFFFF || oCoreAad !== '0 || oCoreBlock !== '0) begin
      n_fail++; $display("FAIL reset_data: got mask=%h, required FFFF with zero blocks", oMask);
    end
    #2 iRst = 0;
    @(negedge iClk);
  endtask

  task automatic test_aad_and_payload();
    start_job();
    send_beat(0, 16, 0, 1);
    send_beat(1, 16, 0, 1);
    iStart = 1;
    @(negedge iClk);
    iStart = 0;
    send_beat(1, 16, 1, 1);
    push_len(16, 32);
    wait_done();
    n_cmp++;
    if (blk_cnt !== 2) begin n_fail++; $display("FAIL t1_blk_count: got %0d, required 2", blk_cnt); end
  endtask

  task automatic test_payload_only();
    start_job();
    send_beat(1, 16, 0, 1);
    send_beat(1, 5, 1, 1);
    push_len(0, 21);
    wait_done();
  endtask

  task automatic test_aad_only();
    start_job();
    send_beat(0, 16, 0, 1);
    send_beat(0, 4, 1, 1);
    push_len(20, 0);
    wait_done();
    n_cmp++;
    if (blk_cnt !== 0) begin n_fail++; $display("FAIL t3_blk_count: got %0d, required 0", blk_cnt); end
  endtask

  task automatic test_aad_after_payload();
    start_job();
    send_beat(1, 16, 0, 1);
    send_beat(0, 16, 0, 0);
    n_cmp++;
    if (oErr !== 1) begin n_fail++; $display("FAIL t4_err: got %b, required 1", oErr); end
    send_beat(1, 8, 1, 1);
    push_len(0, 24);
    wait_done();
    n_cmp++;
    if (oErr !== 1) begin n_fail++; $display("FAIL t4_err_sticky: got %b, required 1", oErr); end
  endtask

  task automatic test_reset_mid_job();
    start_job();
    send_beat(0, 0, 0, 0);
    send_beat(1, 3, 0, 1);
    n_cmp++;
    if (oErr !== 1 || oMask !== 16'hE000) begin n_fail++; $display("FAIL t5_pre: got err=%b mask=%h, required 1 E000", oErr, oMask); end
    #2 iRst = 1;
    #1;
    n_cmp++;
    if (oBusy !== 0 || oCoreInit !== 0 || oErr !== 0 || oMask !== 16'hFFFF) begin
      n_fail++; $display("FAIL t5_async: got busy=%b init=%b err=%b mask=%h, required 0 0 0 FFFF", oBusy, oCoreInit, oErr, oMask);
    end
    @(negedge iClk);
    #2 iRst = 0;
    exp_aad.delete();
    exp_blk.delete();
    @(negedge iClk);
    start_job();
    send_beat(0, 16, 0, 1);
    send_beat(1, 16, 1, 1);
    push_len(16, 16);
    wait_done();
    n_cmp++;
    if (oErr !== 0) begin n_fail++; $display("FAIL t5_clean_err: got %b, required 0", oErr); end
  endtask

  task automatic test_saturate();
    start_job();
    for (int i = 0; i < 18; i++) send_beat(1, 16, 0, 1);
    send_beat(1, 12, 1, 1);
    push_len(0, 300);
    wait_done();
    n_cmp++;
    if (a8 !== {64'd0, 64'd2040}) begin n_fail++; $display("FAIL t6_len8: got %h, required %h", a8, {64'd0, 64'd2040}); end
    n_cmp++;
    if (e8 !== 1) begin n_fail++; $display("FAIL t6_err8: got %b, required 1", e8); end
    n_cmp++;
    if (oErr !== 0) begin n_fail++; $display("FAIL t6_err32: got %b, required 0", oErr); end
  endtask

  initial begin
    test_reset();
    test_aad_and_payload();
    test_payload_only();
    test_aad_only();
    test_aad_after_payload();
    test_reset_mid_job();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
